// File: rtl/axi_lite_fifo_cnt.sv
// AXI4-Lite slave feeding a first-word-fall-through write FIFO, with occupancy,
// threshold and push/pop/drop traffic counters exposed as registers.
module axi_lite_fifo_cnt #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH         = 16,
  localparam int CNT_W             = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     M_TDATA,
  output logic                              M_TVALID,
  input  logic                              M_TREADY,
  output logic [CNT_W-1:0]                  LEVEL,
  output logic                              ALMOST_FULL
);

  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int SW    = C_S_AXI_DATA_WIDTH / 8;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  localparam logic [2:0] A_DATA   = 3'd0;
  localparam logic [2:0] A_STATUS = 3'd1;
  localparam logic [2:0] A_CTRL   = 3'd2;
  localparam logic [2:0] A_THRESH = 3'd3;
  localparam logic [2:0] A_PUSH   = 3'd4;
  localparam logic [2:0] A_POP    = 3'd5;
  localparam logic [2:0] A_DROP   = 3'd6;

  logic             aw_ready_q, aw_ready_d, bvalid_q, bvalid_d;
  logic             ar_ready_q, ar_ready_d, rvalid_q, rvalid_d;
  logic [1:0]       bresp_q, bresp_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic [DW-1:0]    mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] level_q, level_d, thresh_q, thresh_d;
  logic             en_q, en_d, m_tvalid_q, m_tvalid_d, almost_full_q, almost_full_d;
  logic [DW-1:0]    m_tdata_q, m_tdata_d, last_push_q, last_push_d;
  logic [31:0]      push_cnt_q, push_cnt_d, pop_cnt_q, pop_cnt_d, drop_cnt_q, drop_cnt_d;

  logic             wr_hs_s, rd_hs_s, full_s, push_s, pop_s, drop_s;
  logic             ctrl_wr_s, thresh_wr_s, flush_s, clrcnt_s;
  logic [2:0]       waddr_s, raddr_s;
  logic [DW-1:0]    wmask_s, thresh_wide_s, status_s, rmux_s, head_s;
  logic             unused_s;

  assign waddr_s     = S_AXI_AWADDR[4:2];
  assign raddr_s     = S_AXI_ARADDR[4:2];
  assign wr_hs_s     = aw_ready_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_hs_s     = ar_ready_q & S_AXI_ARVALID;
  // Fullness is judged on the registered level, before any pop in the same cycle.
  assign full_s      = (level_q == DEPTH_C);
  assign pop_s       = m_tvalid_q & M_TREADY;
  assign push_s      = wr_hs_s & (waddr_s == A_DATA) & ~full_s;
  assign drop_s      = wr_hs_s & (waddr_s == A_DATA) & full_s;
  assign ctrl_wr_s   = wr_hs_s & (waddr_s == A_CTRL);
  assign thresh_wr_s = wr_hs_s & (waddr_s == A_THRESH);
  assign flush_s     = ctrl_wr_s & S_AXI_WSTRB[0] & S_AXI_WDATA[0];
  assign clrcnt_s    = ctrl_wr_s & S_AXI_WSTRB[0] & S_AXI_WDATA[2];
  assign unused_s    = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR, thresh_wide_s};

  // Byte-strobe expansion and read-data multiplexer.
  always_comb begin
    wmask_s = '0;
    for (int i = 0; i < SW; i++) begin
      wmask_s[i*8 +: 8] = {8{S_AXI_WSTRB[i]}};
    end
    status_s            = '0;
    status_s[CNT_W-1:0] = level_q;
    status_s[16]        = (level_q == '0);
    status_s[17]        = full_s;
    status_s[18]        = almost_full_q;
    case (raddr_s)
      A_DATA:   rmux_s = last_push_q;
      A_STATUS: rmux_s = status_s;
      A_CTRL:   rmux_s = {{(DW-2){1'b0}}, en_q, 1'b0};
      A_THRESH: rmux_s = DW'(thresh_q);
      A_PUSH:   rmux_s = DW'(push_cnt_q);
      A_POP:    rmux_s = DW'(pop_cnt_q);
      A_DROP:   rmux_s = DW'(drop_cnt_q);
      default:  rmux_s = '0;
    endcase
  end

  // Next-state logic for the AXI handshakes, FIFO bookkeeping and counters.
  always_comb begin
    aw_ready_d    = S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q & ~aw_ready_q;
    ar_ready_d    = S_AXI_ARVALID & ~rvalid_q & ~ar_ready_q;
    bvalid_d      = bvalid_q;
    bresp_d       = bresp_q;
    rvalid_d      = rvalid_q;
    rdata_d       = rdata_q;
    thresh_wide_s = (DW'(thresh_q) & ~wmask_s) | (S_AXI_WDATA & wmask_s);

    if (wr_hs_s) begin
      bvalid_d = 1'b1;
      bresp_d  = drop_s ? 2'b10 : 2'b00;
    end else if (S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end else begin
      bvalid_d = bvalid_q;
    end

    if (rd_hs_s) begin
      rvalid_d = 1'b1;
      rdata_d  = rmux_s;
    end else if (S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end else begin
      rvalid_d = rvalid_q;
    end

    en_d        = (ctrl_wr_s & S_AXI_WSTRB[0]) ? S_AXI_WDATA[1] : en_q;
    thresh_d    = thresh_wr_s ? thresh_wide_s[CNT_W-1:0] : thresh_q;
    last_push_d = push_s ? S_AXI_WDATA : last_push_q;

    if (flush_s) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      wr_ptr_d = push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop_s ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      case ({push_s, pop_s})
        2'b10:   level_d = level_q + CNT_W'(1);
        2'b01:   level_d = level_q - CNT_W'(1);
        default: level_d = level_q;
      endcase
    end

    // A word written into the slot that becomes the head must bypass the array.
    head_s        = (push_s && (wr_ptr_q == rd_ptr_d)) ? S_AXI_WDATA : mem_q[rd_ptr_d];
    m_tdata_d     = (level_d != '0) ? head_s : '0;
    m_tvalid_d    = (level_d != '0) & en_d;
    almost_full_d = (level_d >= thresh_d);

    if (clrcnt_s) begin
      push_cnt_d = 32'd0;
      pop_cnt_d  = 32'd0;
      drop_cnt_d = 32'd0;
    end else begin
      push_cnt_d = push_s ? push_cnt_q + 32'd1 : push_cnt_q;
      pop_cnt_d  = pop_s ? pop_cnt_q + 32'd1 : pop_cnt_q;
      drop_cnt_d = (drop_s && (drop_cnt_q != 32'hFFFF_FFFF)) ? drop_cnt_q + 32'd1 : drop_cnt_q;
    end
  end

  // FIFO storage; contents are qualified by level, so no reset is needed.
  always_ff @(posedge S_AXI_ACLK) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= S_AXI_WDATA;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_ready_q    <= 1'b0;
      ar_ready_q    <= 1'b0;
      bvalid_q      <= 1'b0;
      rvalid_q      <= 1'b0;
      bresp_q       <= 2'b00;
      rdata_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      thresh_q      <= DEPTH_C;
      en_q          <= 1'b1;
      m_tvalid_q    <= 1'b0;
      m_tdata_q     <= '0;
      almost_full_q <= 1'b0;
      last_push_q   <= '0;
      push_cnt_q    <= 32'd0;
      pop_cnt_q     <= 32'd0;
      drop_cnt_q    <= 32'd0;
    end else begin
      aw_ready_q    <= aw_ready_d;
      ar_ready_q    <= ar_ready_d;
      bvalid_q      <= bvalid_d;
      rvalid_q      <= rvalid_d;
      bresp_q       <= bresp_d;
      rdata_q       <= rdata_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      thresh_q      <= thresh_d;
      en_q          <= en_d;
      m_tvalid_q    <= m_tvalid_d;
      m_tdata_q     <= m_tdata_d;
      almost_full_q <= almost_full_d;
      last_push_q   <= last_push_d;
      push_cnt_q    <= push_cnt_d;
      pop_cnt_q     <= pop_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign S_AXI_AWREADY = aw_ready_q;
  assign S_AXI_WREADY  = aw_ready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = ar_ready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign M_TVALID      = m_tvalid_q;
  assign M_TDATA       = m_tdata_q;
  assign LEVEL         = level_q;
  assign ALMOST_FULL   = almost_full_q;

endmodule

// File: tb/tb_axi_lite_fifo_cnt.sv
// Bench for axi_lite_fifo_cnt: directed AXI steps plus random traffic, checked
// against a queue-based model of the FIFO, its counters and its control bits.
module tb_axi_lite_fifo_cnt;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  awaddr = 5'd0, araddr = 5'd0;
  logic [2:0]  awprot = 3'd0, arprot = 3'd0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic [3:0]  wstrb = 4'd0;
  logic        awready, wready, bvalid, arready, rvalid, m_tvalid, almost_full;
  logic        m_tready = 1'b0;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata, m_tdata;
  logic [4:0]  level;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [31:0] model_q[$];
  logic [31:0] m_push = 32'd0, m_pop = 32'd0, m_drop = 32'd0, m_last = 32'd0;
  logic        m_en = 1'b1;
  logic [4:0]  m_thresh = 5'd16;
  logic [1:0]  m_exp_resp = 2'b00;
  bit          mon_on = 1'b0;
  bit          m_full;
  int          tready_mode = 0;

  axi_lite_fifo_cnt dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .M_TDATA(m_tdata), .M_TVALID(m_tvalid), .M_TREADY(m_tready),
    .LEVEL(level), .ALMOST_FULL(almost_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Consumer ready pattern: 0 hold low, 1 hold high, 2 toggle, 3 sparse random.
  always @(negedge clk) begin
    case (tready_mode)
      0:       m_tready = 1'b0;
      1:       m_tready = 1'b1;
      2:       m_tready = ~m_tready;
      default: m_tready = ($urandom_range(0, 15) == 0);
    endcase
  end

  // Model: compare observable state, then apply the events of the coming edge.
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      model_q.delete();
      m_push = 32'd0; m_pop = 32'd0; m_drop = 32'd0; m_last = 32'd0;
      m_en = 1'b1; m_thresh = 5'd16;
    end else if (mon_on) begin
      chk("level", 64'(level), 64'(model_q.size()));
      chk("m_tvalid", 64'(m_tvalid), 64'((model_q.size() != 0) && m_en));
      chk("almost_full", 64'(almost_full), 64'(model_q.size() >= int'(m_thresh)));
      m_full = (model_q.size() == DEPTH);
      if (m_tvalid && m_tready && (model_q.size() > 0)) begin
        chk("m_tdata", 64'(m_tdata), 64'(model_q[0]));
        void'(model_q.pop_front());
        m_pop = m_pop + 32'd1;
      end
      if (awready && wready && awvalid && wvalid) begin
        m_exp_resp = 2'b00;
        case (awaddr[4:2])
          3'd0: begin
            if (m_full) begin
              m_exp_resp = 2'b10;
              if (m_drop != 32'hFFFF_FFFF) m_drop = m_drop + 32'd1;
            end else begin
              model_q.push_back(wdata);
              m_push = m_push + 32'd1;
              m_last = wdata;
            end
          end
          3'd2: begin
            if (wstrb[0]) begin
              if (wdata[0]) model_q.delete();
              m_en = wdata[1];
              if (wdata[2]) begin m_push = 32'd0; m_pop = 32'd0; m_drop = 32'd0; end
            end
          end
          3'd3: if (wstrb[0]) m_thresh = wdata[4:0];
          default: ;
        endcase
      end
    end
  end

  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int n;
    @(negedge clk);
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while (!awready && n < 20) begin @(negedge clk); n++; end
    chk("aw_handshake_bound", 64'(n < 20), 64'd1);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    chk("bvalid_bound", 64'(n < 20), 64'd1);
    resp = bresp;
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] addr, output logic [31:0] data);
    int n;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    chk("ar_handshake_bound", 64'(n < 20), 64'd1);
    @(negedge clk);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    chk("rvalid_bound", 64'(n < 20), 64'd1);
    chk("rresp", 64'(rresp), 64'd0);
    data = rdata;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (model_q.size() != 0 && n < 500) begin @(negedge clk); n++; end
    chk(tag, 64'(n < 500), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  rsp;
    logic [31:0] reset_vals [8];
    int          n;

    // Reset, with request valids driven to prove no handshake starts.
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_handshakes", 64'({awready, wready, bvalid, bresp, arready, rvalid, rresp}), 64'd0);
    chk("reset_datapath", {rdata, m_tdata}, 64'd0);
    chk("reset_stream", 64'({m_tvalid, level, almost_full}), 64'd0);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mon_on = 1'b1;

    reset_vals = '{32'd0, 32'h0001_0000, 32'h2, 32'd16, 32'd0, 32'd0, 32'd0, 32'd0};
    for (int i = 0; i < 8; i++) begin
      axi_read(5'(i * 4), rd);
      chk($sformatf("reset_reg_%0h", i * 4), 64'(rd), 64'(reset_vals[i]));
    end

    // Fill with 1..16 while the consumer stalls.
    tready_mode = 0;
    for (int i = 1; i <= 16; i++) begin
      axi_write(5'h00, 32'(i), 4'hF, rsp);
      chk("fill_bresp", 64'(rsp), 64'd0);
    end
    axi_read(5'h04, rd);
    // Level 16, full, and almost_full since LEVEL >= THRESH (16).
    chk("status_full", 64'(rd), 64'((32'd1 << 18) | (32'd1 << 17) | 32'd16));
    chk("af_full", 64'(almost_full), 64'd1);
    axi_read(5'h10, rd);
    chk("push_cnt_16", 64'(rd), 64'd16);

    // Push while full is dropped.
    axi_write(5'h00, 32'hDEAD_BEEF, 4'hF, rsp);
    chk("drop_bresp", 64'(rsp), 64'd2);
    axi_read(5'h18, rd);
    chk("drop_cnt_1", 64'(rd), 64'd1);
    chk("level_after_drop", 64'(level), 64'd16);
    axi_read(5'h00, rd);
    chk("data_last_accepted", 64'(rd), 64'd16);

    tready_mode = 1;
    wait_drain("drain1_bound");
    axi_read(5'h14, rd);
    chk("pop_cnt_16", 64'(rd), 64'd16);
    axi_read(5'h04, rd);
    chk("status_empty", 64'(rd), 64'h1_0000);

    // Clear counters, then stream 40 words with a toggling consumer.
    axi_write(5'h08, 32'h6, 4'hF, rsp);
    tready_mode = 2;
    for (int i = 0; i < 40; i++) begin
      axi_write(5'h00, $urandom, 4'hF, rsp);
      chk("stream_bresp", 64'(rsp), 64'd0);
    end
    tready_mode = 1;
    wait_drain("drain2_bound");
    axi_read(5'h10, rd);
    chk("push_cnt_40", 64'(rd), 64'd40);
    axi_read(5'h14, rd);
    chk("pop_cnt_40", 64'(rd), 64'd40);
    axi_read(5'h18, rd);
    chk("drop_cnt_0", 64'(rd), 64'd0);

    // Threshold, disable, strobes, ignored writes, flush and counter clear.
    tready_mode = 0;
    axi_write(5'h0C, 32'd4, 4'hF, rsp);
    axi_write(5'h08, 32'h0, 4'hF, rsp);
    for (int i = 0; i < 5; i++) axi_write(5'h00, $urandom, 4'hF, rsp);
    @(negedge clk);
    chk("af_thresh4", 64'(almost_full), 64'd1);
    chk("tvalid_disabled", 64'(m_tvalid), 64'd0);
    axi_write(5'h0C, 32'h0000_0009, 4'b0010, rsp);
    axi_read(5'h0C, rd);
    chk("thresh_strobe", 64'(rd), 64'd4);
    axi_write(5'h1C, 32'hFFFF_FFFF, 4'hF, rsp);
    chk("rsvd_bresp", 64'(rsp), 64'd0);
    axi_write(5'h04, 32'hFFFF_FFFF, 4'hF, rsp);
    chk("ro_bresp", 64'(rsp), 64'd0);
    axi_read(5'h04, rd);
    chk("status_5_af", 64'(rd), 64'((32'd1 << 18) | 32'd5));
    axi_read(5'h1C, rd);
    chk("rsvd_read", 64'(rd), 64'd0);
    axi_write(5'h08, 32'h3, 4'hF, rsp);
    chk("level_flush", 64'(level), 64'd0);
    axi_read(5'h08, rd);
    chk("ctrl_after_flush", 64'(rd), 64'h2);
    axi_write(5'h08, 32'h6, 4'hF, rsp);
    axi_read(5'h10, rd);
    chk("push_cnt_clr", 64'(rd), 64'd0);
    axi_read(5'h14, rd);
    chk("pop_cnt_clr", 64'(rd), 64'd0);
    axi_read(5'h18, rd);
    chk("drop_cnt_clr", 64'(rd), 64'd0);
    axi_read(5'h08, rd);
    chk("ctrl_en", 64'(rd), 64'h2);

    // Random traffic with a sparse consumer so the FIFO fills and drops.
    tready_mode = 3;
    for (int i = 0; i < 40; i++) begin
      axi_write(5'h00, $urandom, 4'hF, rsp);
      chk("rand_bresp", 64'(rsp), 64'(m_exp_resp));
    end
    tready_mode = 1;
    wait_drain("drain3_bound");
    axi_read(5'h10, rd);
    chk("rand_push_cnt", 64'(rd), 64'(m_push));
    axi_read(5'h14, rd);
    chk("rand_pop_cnt", 64'(rd), 64'(m_pop));
    axi_read(5'h18, rd);
    chk("rand_drop_cnt", 64'(rd), 64'(m_drop));
    axi_read(5'h00, rd);
    chk("rand_last", 64'(rd), 64'(m_last));

    // Reset while a write response is pending and three words are queued.
    tready_mode = 0;
    for (int i = 0; i < 3; i++) axi_write(5'h00, $urandom, 4'hF, rsp);
    @(negedge clk);
    awaddr = 5'h0C; wdata = 32'd7; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while (!awready && n < 20) begin @(negedge clk); n++; end
    chk("rst_aw_bound", 64'(n < 20), 64'd1);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    chk("bvalid_pending", 64'(bvalid), 64'd1);
    chk("level_pre_rst", 64'(level), 64'd3);
    rst_n = 1'b0;
    #1;
    chk("bvalid_in_rst", 64'(bvalid), 64'd0);
    chk("level_in_rst", 64'(level), 64'd0);
    chk("tvalid_in_rst", 64'(m_tvalid), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    axi_read(5'h0C, rd);
    chk("thresh_after_rst", 64'(rd), 64'd16);
    axi_read(5'h04, rd);
    chk("status_after_rst", 64'(rd), 64'h1_0000);
    axi_read(5'h08, rd);
    chk("ctrl_after_rst", 64'(rd), 64'h2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
